// File: rtl/hsk_pack_if.sv
// hsk_pack_if: bundles the beat-side and word-side handshakes of hsk_pack.
//   in_vld/in_rdy/in_dat/in_last      narrow beat stream into the packer
//   out_vld/out_rdy/out_dat/out_cnt/out_last   packed word stream out of it
// Modports: master = environment (drives beats, sinks words), slave = packer.
interface hsk_pack_if #(
    parameter int unsigned IW    = 8,
    parameter int unsigned RATIO = 4,
    parameter int unsigned CW    = $clog2(RATIO + 1)
);
    logic                  in_vld;
    logic                  in_rdy;
    logic [IW-1:0]         in_dat;
    logic                  in_last;
    logic                  out_vld;
    logic                  out_rdy;
    logic [IW*RATIO-1:0]   out_dat;
    logic [CW-1:0]         out_cnt;
    logic                  out_last;

    modport master (
        output in_vld, in_dat, in_last, out_rdy,
        input  in_rdy, out_vld, out_dat, out_cnt, out_last
    );

    modport slave (
        input  in_vld, in_dat, in_last, out_rdy,
        output in_rdy, out_vld, out_dat, out_cnt, out_last
    );
endinterface

// File: rtl/hsk_pack.sv
// hsk_pack: collects RATIO beats of IW bits into one IW*RATIO-bit word (first beat in the LSBs).
// in_last closes a word early; out_cnt gives the number of valid lanes, unused lanes read 0.
// Output fields are frozen while out_vld is high, so it can feed a slow handshake crossing.
// Ports:
//   clk, rst_n     single clock, asynchronous active-low reset
//   bus (slave)    in_vld/in_rdy/in_dat/in_last beat side, out_vld/out_rdy/out_dat/out_cnt/
//                  out_last word side
// Build option: define HSK_PACK_SKID_EN to split the accumulator from the output register so
// beats keep flowing while a word waits (one beat per cycle peak). Undefined: a single register,
// no beat accepted while a word is pending.
module hsk_pack #(
    parameter int unsigned IW    = 8,
    parameter int unsigned RATIO = 4,
    parameter int unsigned CW    = $clog2(RATIO + 1)
) (
    input logic       clk,
    input logic       rst_n,
    hsk_pack_if.slave bus
);
    localparam int unsigned   OW      = IW * RATIO;
    localparam logic [CW-1:0] LastIdx = CW'(RATIO - 1);

    typedef enum logic [0:0] {StFill, StFull} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] merged;
    logic [CW-1:0] close_cnt;
    logic          in_rdy;
    logic          accept;
    logic          closing;

    assign accept    = bus.in_vld && in_rdy;
    assign closing   = accept && (bus.in_last || (idx_q == LastIdx));
    assign close_cnt = idx_q + CW'(1);

    // Lane 0 starts a fresh word, so lanes beyond the closing beat read 0.
    always_comb begin
        merged = (idx_q == '0) ? '0 : acc_q;
        merged[int'(idx_q) * IW +: IW] = bus.in_dat;
    end

`ifndef HSK_PACK_SKID_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;

    assign in_rdy = (state_q == StFill);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    acc_d = merged;
                    idx_d = closing ? '0 : idx_q + CW'(1);
                end
                if (closing) begin
                    state_d = StFull;
                    cnt_d   = close_cnt;
                    last_d  = bus.in_last;
                end
            end
            StFull: begin
                if (bus.out_rdy) state_d = StFill;
            end
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        bus.in_rdy   = in_rdy;
        bus.out_vld  = (state_q == StFull);
        bus.out_dat  = acc_q;
        bus.out_cnt  = cnt_q;
        bus.out_last = last_q;
    end
`else
    logic          held_q, held_d;      // closed word parked in acc_q
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic          hlast_q, hlast_d;
    logic [OW-1:0] odat_q, odat_d;
    logic [CW-1:0] ocnt_q, ocnt_d;
    logic          olast_q, olast_d;
    logic          out_free;
    logic          move;

    assign in_rdy   = !held_q;
    assign out_free = (state_q == StFill) || bus.out_rdy;
    // A parked word implies StFull; it advances on the output handshake.
    assign move     = held_q && bus.out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
            idx_q   <= '0;
            acc_q   <= '0;
            held_q  <= 1'b0;
            hcnt_q  <= '0;
            hlast_q <= 1'b0;
            odat_q  <= '0;
            ocnt_q  <= '0;
            olast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            held_q  <= held_d;
            hcnt_q  <= hcnt_d;
            hlast_q <= hlast_d;
            odat_q  <= odat_d;
            ocnt_q  <= ocnt_d;
            olast_q <= olast_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        held_d  = held_q;
        hcnt_d  = hcnt_q;
        hlast_d = hlast_q;
        odat_d  = odat_q;
        ocnt_d  = ocnt_q;
        olast_d = olast_q;
        if (accept) begin
            acc_d = merged;
            idx_d = closing ? '0 : idx_q + CW'(1);
        end
        if (closing && out_free) begin
            odat_d  = merged;
            ocnt_d  = close_cnt;
            olast_d = bus.in_last;
        end else if (closing) begin
            held_d  = 1'b1;
            hcnt_d  = close_cnt;
            hlast_d = bus.in_last;
        end
        // move and closing are exclusive: nothing is accepted while a word is parked.
        if (move) begin
            odat_d  = acc_q;
            ocnt_d  = hcnt_q;
            olast_d = hlast_q;
            held_d  = 1'b0;
        end
        unique case (state_q)
            StFill: begin
                if (closing) state_d = StFull;
            end
            StFull: begin
                if (bus.out_rdy && !move && !closing) state_d = StFill;
            end
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        bus.in_rdy   = in_rdy;
        bus.out_vld  = (state_q == StFull);
        bus.out_dat  = odat_q;
        bus.out_cnt  = ocnt_q;
        bus.out_last = olast_q;
    end
`endif
endmodule

// File: tb/tb_hsk_pack.sv
// tb_hsk_pack: directed vectors for hsk_pack (IW=8, RATIO=4) with hand-computed words.
// Expectations follow the build selected by HSK_PACK_SKID_EN.
module tb_hsk_pack;
    localparam int unsigned IW    = 8;
    localparam int unsigned RATIO = 4;
`ifdef HSK_PACK_SKID_EN
    localparam int GAP    = 4;
    localparam int BP_ACC = 4;
`else
    localparam int GAP    = 5;
    localparam int BP_ACC = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    hsk_pack_if #(.IW(IW), .RATIO(RATIO)) bus ();

    hsk_pack #(.IW(IW), .RATIO(RATIO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] dat, input int cnt,
                              input logic last);
        check({tag, "_vld"}, 64'(bus.out_vld), 64'd1);
        check({tag, "_dat"}, 64'(bus.out_dat), 64'(dat));
        check({tag, "_cnt"}, 64'(bus.out_cnt), 64'(cnt));
        check({tag, "_last"}, 64'(bus.out_last), 64'(last));
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int n = 0;
        bus.in_vld  = 1'b1;
        bus.in_dat  = d;
        bus.in_last = l;
        while (!bus.in_rdy && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("rdy_timeout", 64'(bus.in_rdy), 64'd1);
        step();
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
    endtask

    function automatic logic [7:0] tp_beat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [31:0] tp_word(input int w);
        return {tp_beat(4 * w + 3), tp_beat(4 * w + 2), tp_beat(4 * w + 1), tp_beat(4 * w)};
    endfunction

    initial begin
        int          accepts;
        logic [7:0]  d;
        int          sent;
        int          words;
        int          last_cyc;

        bus.in_vld  = 1'b0;
        bus.in_dat  = '0;
        bus.in_last = 1'b0;
        bus.out_rdy = 1'b1;
        rst_n       = 1'b0;
        #2;
        check("rst_rdy", 64'(bus.in_rdy), 64'd1);
        check("rst_vld", 64'(bus.out_vld), 64'd0);
        check("rst_dat", 64'(bus.out_dat), 64'd0);
        check("rst_cnt", 64'(bus.out_cnt), 64'd0);
        check("rst_last", 64'(bus.out_last), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Four full beats
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        check_word("four", 32'h44332211, 4, 1'b0);
        step();

        // Early last
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        check_word("early", 32'h0000BBAA, 2, 1'b1);
        step();

        // Last on the final lane: one word, nothing after it
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h04, 1'b1);
        check_word("fulllast", 32'h04030201, 4, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            check("no_extra", 64'(bus.out_vld), 64'd0);
            step();
        end

        // Backpressure
        bus.out_rdy = 1'b0;
        send_beat(8'h50, 1'b0);
        send_beat(8'h51, 1'b0);
        send_beat(8'h52, 1'b0);
        send_beat(8'h53, 1'b0);
        check_word("bp_word", 32'h53525150, 4, 1'b0);
        accepts = 0;
        d = 8'h60;
        for (int i = 0; i < 20; i++) begin
            check_word("bp_hold", 32'h53525150, 4, 1'b0);
`ifndef HSK_PACK_SKID_EN
            check("bp_rdy", 64'(bus.in_rdy), 64'd0);
`endif
            bus.in_vld = 1'b1;
            bus.in_dat = d;
            if (bus.in_rdy) begin
                accepts++;
                d++;
            end
            step();
        end
        bus.in_vld = 1'b0;
        check("bp_accepts", 64'(accepts), 64'(BP_ACC));
        check("bp_rdy_end", 64'(bus.in_rdy), 64'd0);
        bus.out_rdy = 1'b1;
        check_word("bp_release", 32'h53525150, 4, 1'b0);
        step();
`ifdef HSK_PACK_SKID_EN
        check_word("bp_skid", 32'h63626160, 4, 1'b0);
        check("bp_skid_rdy", 64'(bus.in_rdy), 64'd1);
        step();
`endif
        check("bp_idle_vld", 64'(bus.out_vld), 64'd0);
        check("bp_idle_rdy", 64'(bus.in_rdy), 64'd1);

        // Throughput: 40 beats streamed, 10 words in order
        sent     = 0;
        words    = 0;
        last_cyc = -1;
        for (int cyc = 0; cyc < 200 && words < 10; cyc++) begin
            if (bus.out_vld) begin
                check("tp_dat", 64'(bus.out_dat), 64'(tp_word(words)));
                check("tp_cnt", 64'(bus.out_cnt), 64'd4);
                if (words > 0) check("tp_gap", 64'(cyc - last_cyc), 64'(GAP));
                last_cyc = cyc;
                words++;
            end
            if (bus.in_rdy && sent < 40) begin
                bus.in_vld = 1'b1;
                bus.in_dat = tp_beat(sent);
                sent++;
            end else begin
                bus.in_vld = 1'b0;
            end
            step();
        end
        bus.in_vld = 1'b0;
        check("tp_words", 64'(words), 64'd10);
        step();

        // Reset mid-word
        send_beat(8'hE1, 1'b0);
        send_beat(8'hE2, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mr_vld", 64'(bus.out_vld), 64'd0);
        check("mr_rdy", 64'(bus.in_rdy), 64'd1);
        check("mr_dat", 64'(bus.out_dat), 64'd0);
        check("mr_cnt", 64'(bus.out_cnt), 64'd0);
        check("mr_last", 64'(bus.out_last), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        send_beat(8'hF1, 1'b0);
        send_beat(8'hF2, 1'b0);
        send_beat(8'hF3, 1'b0);
        send_beat(8'hF4, 1'b0);
        check_word("post_rst", 32'hF4F3F2F1, 4, 1'b0);
        step();
        check("post_rst_idle", 64'(bus.out_vld), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hsk_pack.md
# hsk_pack

Single-clock width packer placed directly upstream of `cdc_hsk` on the source side. It collects `RATIO` narrow beats of `IW` bits into one `IW*RATIO`-bit word, so that one slow handshake crossing carries several beats. An `in_last` marker closes a partial word early. The output holds data stable while valid, as `cdc_hsk` `src_*` requires.

## Interface
- `IW`, default 8: input beat width in bits.
- `RATIO`, default 4: beats per output word; legal range 1 and up.
- `CW`, default `$clog2(RATIO+1)`: width of `out_cnt`.
- `clk`, input, 1: single clock; all logic is `posedge clk`.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_vld`, input, 1: input beat valid.
- `in_rdy`, output, 1: packer accepts a beat this cycle.
- `in_dat`, input, `IW`: input beat.
- `in_last`, input, 1: the beat closes the current word. Sampled only on acceptance.
- `out_vld`, output, 1: packed word valid.
- `out_rdy`, input, 1: consumer accepts the word. Connects to `cdc_hsk.src_rdy`.
- `out_dat`, output, `IW*RATIO`: packed word.
- `out_cnt`, output, `CW`: number of valid lanes, 1..`RATIO`.
- `out_last`, output, 1: the word was closed by `in_last`.

## Operation
- A beat is accepted on a rising edge where `in_vld && in_rdy`. A word is transferred on a rising edge where `out_vld && out_rdy`.
- Lane index `idx` counts 0..`RATIO-1`. Beat k of a word is written to `out_dat[k*IW +: IW]`, so the first beat lands in the LSBs.
- A word closes on the accepted beat where `idx==RATIO-1` or `in_last==1`. After closing, `idx` returns to 0.
- `out_cnt` is `idx+1` at close. Lanes at or above `out_cnt` read 0, because the accumulator is cleared at the start of each word.
- `out_last` is 1 only if the closing beat had `in_last`. If `in_last` arrives on lane `RATIO-1`, the result is one word with `out_cnt==RATIO` and `out_last==1`.
- A zero-count word is never emitted.
- States: `FILL` (collecting, `out_vld=0`) and `FULL` (`out_vld=1`, `out_*` frozen).
  - `FILL` to `FULL` on the closing beat.
  - `FULL` to `FILL` on the output handshake.
- Base build: `in_rdy = !out_vld`. No beat is accepted in `FULL`.
- `in_dat` and `in_last` are ignored while `in_rdy==0`.
- Reset at any time discards any partial or pending word.

## Timing
- Reset values:
  - `out_vld=0`, `out_dat=0`, `out_cnt=0`, `out_last=0`.
  - `idx=0`, state `FILL`.
  - `in_rdy=1`, including during reset.
- Latency: a closing beat accepted at edge t gives `out_vld=1` after edge t, visible in cycle t+1.
- `out_dat`, `out_cnt` and `out_last` stay constant from `out_vld` rise until the handshake edge.
- `out_vld` never drops without a handshake.
- Base build: output handshake at edge t gives `in_rdy=1` in cycle t+1. Peak throughput is one word per `RATIO+1` cycles.
- `RATIO==1`: every accepted beat is a word with `out_cnt=1`.

## Configuration
- `HSK_PACK_SKID_EN` defined: the accumulator and the output register are separate.
  - Beats keep filling the accumulator while the output register waits.
  - A closing beat loads the output register directly if `!out_vld || out_rdy` in that cycle, with latency 1.
  - Otherwise the closed word is held in the accumulator and `in_rdy=0`. It moves to the output register on the handshake edge, and `in_rdy=1` the next cycle.
  - Peak throughput is one beat per cycle.
- `HSK_PACK_SKID_EN` undefined: single register, base behaviour above.
- Port list, reset values and word format are identical in both builds.

## Test plan
- Four beats with `out_rdy=1`, `RATIO=4`, `IW=8`: accept 0x11, 0x22, 0x33, 0x44 with `in_last=0`. Expect `out_dat=0x44332211`, `out_cnt=4`, `out_last=0` one cycle after the 4th accept.
- Early last: accept 0xAA then 0xBB with `in_last=1`. Expect `out_dat=0x0000BBAA`, `out_cnt=2`, `out_last=1`, then `idx` back at 0.
- Last on full lane: 4 beats with `in_last` on the 4th. Expect exactly one word with `out_cnt=4` and `out_last=1`, and no extra word.
- Backpressure: hold `out_rdy=0` for 20 cycles with `out_vld=1`.
  - Expect `out_*` unchanged throughout.
  - Base build: `in_rdy=0` throughout.
  - Skid build: next 4 beats accepted, then `in_rdy=0`.
- Throughput: `in_vld=1` continuously, `out_rdy=1`, 40 beats. Expect 10 words, spaced 5 cycles apart in the base build and 4 cycles apart in the skid build, with data in order.
- Reset mid-word: assert `rst_n=0` after 2 beats, then release. Expect all outputs at reset values immediately, and the next 4 beats produce one word containing only post-reset data.
- Integration with `cdc_hsk`, clock ratios 5/7 and 7/3: 100 random words. Expect every `dst_dat` equal to the packed reference, in order.
